// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: opcodes, ALU select codes
// and the FSM state encoding.
package alu_issue_ctrl_pkg;

   localparam logic [2:0] OP_NEG = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_CLR = 3'b011;
   localparam logic [2:0] OP_LDI = 3'b100;

   localparam logic [1:0] SEL_NEG  = 2'b00;
   localparam logic [1:0] SEL_ADD  = 2'b01;
   localparam logic [1:0] SEL_AND  = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two combinational read ports, one synchronous
// write port, all entries cleared by the asynchronous reset.
module alu_regfile #(
   parameter int DW   = 8,
   parameter int NREG = 4,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd
);

   logic [DW-1:0] regs [NREG];

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of an external 8-bit ALU: one
// instruction in flight, sequenced IDLE -> READ -> EXEC -> WB.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NREG = 4,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   input  logic [DW-1:0] in_imm,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_s,
   input  logic [DW-1:0] alu_y,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [AW-1:0] res_rd,
   output logic          res_zero,
   output logic          res_err,
   output logic          busy
);

   state_t        state_q, state_d;
   logic [1:0]    sel_q;
   logic [AW-1:0] rs1_q, rs2_q;
   logic [DW-1:0] rf_rd1, rf_rd2;
   logic          accept, wb_fire, rf_we;

   // Both ports transfer on the rising edge where valid and ready are high;
   // the result port holds all res_* fields stable until that edge.
   assign in_ready  = (state_q == ST_IDLE);
   assign accept    = in_valid & in_ready;
   assign res_valid = (state_q == ST_WB);
   assign wb_fire   = res_valid & res_ready;
   assign busy      = (state_q != ST_IDLE);
   assign res_zero  = res_valid && (res_data == '0);
   assign rf_we     = wb_fire & ~res_err;

   alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1_q),
      .ra2 (rs2_q),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2),
      .we  (rf_we),
      .wa  (res_rd),
      .wd  (res_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // Opcodes with bit 2 clear go through the ALU; LDI and illegal
               // codes produce their result directly.
               state_d = in_op[2] ? ST_WB : ST_READ;
            end
         end
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB: begin
            if (wb_fire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q    <= SEL_ZERO;
         rs1_q    <= '0;
         rs2_q    <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_s    <= SEL_ZERO;
         res_data <= '0;
         res_rd   <= '0;
         res_err  <= 1'b0;
      end else begin
         if (accept) begin
            sel_q  <= in_op[1:0];
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
            res_rd <= in_rd;
            if (!in_op[2]) begin
               res_err <= 1'b0;
            end else if (in_op == OP_LDI) begin
               res_data <= in_imm;
               res_err  <= 1'b0;
            end else begin
               res_data <= '0;
               res_err  <= 1'b1;
            end
         end
         if (state_q == ST_READ) begin
            alu_a <= rf_rd1;
            alu_b <= rf_rd2;
            alu_s <= sel_q;
         end
         if (state_q == ST_EXEC) begin
            res_data <= alu_y;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, throughput and reset
// sequences, and random instructions checked against a register model.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int DW   = 8;
   localparam int NREG = 4;
   localparam int AW   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = 3'b000;
   logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [DW-1:0] in_imm = '0;
   logic [DW-1:0] alu_a, alu_b, alu_y;
   logic [1:0]    alu_s;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_data;
   logic [AW-1:0] res_rd;
   logic          res_zero, res_err, busy;

   alu_issue_ctrl #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s     (alu_s),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_rd    (res_rd),
      .res_zero  (res_zero),
      .res_err   (res_err),
      .busy      (busy)
   );

   // ---------------- clock / external ALU ----------------
   always #5 clk = ~clk;

   always_comb begin
      case (alu_s)
         SEL_NEG: alu_y = ~alu_a + 8'd1;
         SEL_ADD: alu_y = alu_a + alu_b;
         SEL_AND: alu_y = alu_a & alu_b;
         default: alu_y = 8'd0;
      endcase
   end

   // ---------------- scoreboard / model ----------------
   int          n_checks = 0;
   int          n_pass = 0;
   int          model_regs [NREG];
   logic [11:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Result record layout: {err, zero, rd[1:0], data[7:0]}
   function automatic logic [11:0] model_result(input logic [2:0] op, input logic [1:0] rd,
                                                input logic [1:0] rs1, input logic [1:0] rs2,
                                                input logic [7:0] imm);
      int a;
      int b;
      int y;
      logic err;
      a = model_regs[rs1];
      b = model_regs[rs2];
      err = 1'b0;
      case (op)
         3'd0: y = (256 - a) % 256;
         3'd1: y = (a + b) % 256;
         3'd2: y = a & b;
         3'd3: y = 0;
         3'd4: y = int'(imm);
         default: begin y = 0; err = 1'b1; end
      endcase
      return {err, (y == 0), rd, y[7:0]};
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, input int hold,
                        output logic [11:0] got, output int lat, output logic [1:0] s_seen);
      logic [11:0] pred;
      pred = model_result(op, rd, rs1, rs2, imm);
      exp_q.push_back(pred);
      got = '0;
      s_seen = 2'b00;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      res_ready = (hold == 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (res_valid) break;
         if (lat >= 20) begin
            check("res_valid_timeout", 32'd0, 32'd1);
            return;
         end
      end
      got = {res_err, res_zero, res_rd, res_data};
      s_seen = alu_s;
      for (int i = 0; i < hold; i++) begin
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_res_valid", 32'(res_valid), 32'd1);
         check("hold_result", 32'({res_err, res_zero, res_rd, res_data}), 32'(got));
         check("hold_no_write", 32'(dut.u_rf.regs[rd]), 32'(model_regs[rd]));
         in_valid = 1'($urandom_range(0, 1));
         in_op = OP_LDI; in_rd = rd; in_imm = ~imm;
         @(negedge clk);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      check("res_valid_drop", 32'(res_valid), 32'd0);
      if (!pred[11]) model_regs[rd] = int'(pred[7:0]);
      check("wb_reg", 32'(dut.u_rf.regs[rd]), 32'(model_regs[rd]));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [7:0] imm;
      int         hold;
      logic [7:0] data;
      logic       zero;
      logic       err;
      int         lat;
      int         sel;   // -1: alu_s not checked
   } vec_t;

   vec_t tbl [$];

   initial begin
      logic [11:0] got;
      logic [11:0] exp;
      logic [1:0]  s_seen;
      int          lat;
      int          cnt;
      logic [2:0]  rop;

      for (int i = 0; i < NREG; i++) model_regs[i] = 0;

      tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05, 0,  8'h05, 1'b0, 1'b0, 1, -1});
      tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03, 0,  8'h03, 1'b0, 1'b0, 1, -1});
      tbl.push_back('{OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 0,  8'h08, 1'b0, 1'b0, 3, 1});
      tbl.push_back('{OP_NEG, 2'd0, 2'd1, 2'd0, 8'h00, 0,  8'hFB, 1'b0, 1'b0, 3, 0});
      tbl.push_back('{OP_AND, 2'd0, 2'd0, 2'd2, 8'h00, 0,  8'h03, 1'b0, 1'b0, 3, 2});
      tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF, 0,  8'hFF, 1'b0, 1'b0, 1, -1});
      tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01, 0,  8'h01, 1'b0, 1'b0, 1, -1});
      tbl.push_back('{OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 0,  8'h00, 1'b1, 1'b0, 3, 1});
      tbl.push_back('{OP_CLR, 2'd2, 2'd0, 2'd0, 8'h00, 0,  8'h00, 1'b1, 1'b0, 3, 3});
      tbl.push_back('{OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 10, 8'hFF, 1'b0, 1'b0, 3, 1});
      tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h5A, 0,  8'h5A, 1'b0, 1'b0, 1, -1});
      tbl.push_back('{3'b110, 2'd2, 2'd1, 2'd1, 8'h77, 0,  8'h00, 1'b1, 1'b1, 1, -1});
      tbl.push_back('{OP_AND, 2'd1, 2'd2, 2'd2, 8'h00, 0,  8'h5A, 1'b0, 1'b0, 3, 2});
      tbl.push_back('{OP_LDI, 2'd3, 2'd0, 2'd0, 8'h00, 0,  8'h00, 1'b1, 1'b0, 1, -1});
      tbl.push_back('{OP_NEG, 2'd3, 2'd3, 2'd0, 8'h00, 0,  8'h00, 1'b1, 1'b0, 3, 0});
      tbl.push_back('{OP_NEG, 2'd1, 2'd0, 2'd0, 8'h00, 0,  8'h01, 1'b0, 1'b0, 3, 0});
      tbl.push_back('{3'b111, 2'd1, 2'd0, 2'd0, 8'h33, 3,  8'h00, 1'b1, 1'b1, 1, -1});
      tbl.push_back('{OP_ADD, 2'd0, 2'd1, 2'd1, 8'h00, 0,  8'h02, 1'b0, 1'b0, 3, 1});

      // reset state
      repeat (2) @(negedge clk);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_s", 32'(alu_s), 32'd3);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_rd", 32'(res_rd), 32'd0);
      check("rst_res_zero", 32'(res_zero), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      foreach (tbl[k]) begin
         issue(tbl[k].op, tbl[k].rd, tbl[k].rs1, tbl[k].rs2, tbl[k].imm, tbl[k].hold,
               got, lat, s_seen);
         void'(exp_q.pop_front());
         check($sformatf("vec%0d_data", k), 32'(got[7:0]), 32'(tbl[k].data));
         check($sformatf("vec%0d_rd", k), 32'(got[9:8]), 32'(tbl[k].rd));
         check($sformatf("vec%0d_zero", k), 32'(got[10]), 32'(tbl[k].zero));
         check($sformatf("vec%0d_err", k), 32'(got[11]), 32'(tbl[k].err));
         check($sformatf("vec%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
         if (tbl[k].sel >= 0) check($sformatf("vec%0d_alu_s", k), 32'(s_seen), 32'(tbl[k].sel));
      end

      // throughput with in_valid and res_ready held high
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_LDI; in_rd = 2'd0; in_imm = 8'h11; res_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (in_ready) cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("thru_ldi", 32'(cnt), 32'd8);
      model_regs[0] = 8'h11;
      for (int i = 0; i < 10 && busy; i++) @(negedge clk);
      check("thru_ldi_idle", 32'(busy), 32'd0);
      in_valid = 1'b1; in_op = OP_AND; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (in_ready) cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("thru_alu", 32'(cnt), 32'd4);
      for (int i = 0; i < 10 && busy; i++) @(negedge clk);
      check("thru_alu_idle", 32'(busy), 32'd0);
      res_ready = 1'b0;
      check("thru_r0", 32'(dut.u_rf.regs[0]), 32'(model_regs[0]));

      // random instructions against the model
      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         issue(rop, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 2), got, lat, s_seen);
         exp = exp_q.pop_front();
         check($sformatf("rnd%0d_result", n), 32'(got), 32'(exp));
         check($sformatf("rnd%0d_lat", n), 32'(lat), (rop[2] ? 32'd1 : 32'd3));
      end

      // reset asserted during EXEC of an ADD
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_ADD; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
      res_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("rstx_busy_read", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstx_alu_s", 32'(alu_s), 32'd3);
      check("rstx_alu_a", 32'(alu_a), 32'd0);
      check("rstx_res_valid", 32'(res_valid), 32'd0);
      check("rstx_res_data", 32'(res_data), 32'd0);
      check("rstx_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      res_ready = 1'b0;
      for (int i = 0; i < NREG; i++) model_regs[i] = 0;
      #1;
      check("rstx_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < NREG; i++) begin
         issue(OP_AND, 2'(i), 2'(i), 2'(i), 8'h00, 0, got, lat, s_seen);
         void'(exp_q.pop_front());
         check($sformatf("rstx_r%0d", i), 32'(got[7:0]), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
